// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains a FIFO through its read port and sends each word as an
//            asynchronous UART frame: start bit, data LSB first, optional
//            even parity bit, stop bit. Bit period is CLKS_PER_BIT clocks.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            enable          - permits new pops (sampled in IDLE / last STOP)
//            fifo_empty      - FIFO empty flag
//            fifo_rdata      - FIFO registered read data
//            fifo_renable    - FIFO read strobe, one cycle per frame
//            tx              - serial line, idles high
//            busy            - high whenever the FSM is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_renable,
    output logic                  tx,
    output logic                  busy
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_w = $clog2(DATA_WIDTH) + 1;

    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_baud_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_bit_last  = c_idx_w'(DATA_WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_cnt_w-1:0]      r_baud_cnt;
    logic [c_idx_w-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_parity;

    logic                    w_counting;
    logic                    w_bit_done;
    logic                    w_pop_ok;
    logic                    w_tx;
    logic                    w_renable;
    logic                    w_busy;

    // Only the serial states run the baud counter; POP/LOAD are single cycles.
    assign w_counting = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_bit_done = w_counting && (r_baud_cnt == c_baud_last);
    assign w_pop_ok   = enable && !fifo_empty;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_tx         = 1'b1;
        w_renable    = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_pop_ok) begin
                    w_state_next = S_POP;
                end
            end
            S_POP: begin
                w_renable    = 1'b1;
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = S_START;
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_bit_done) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_done && (r_bit_idx == c_bit_last)) begin
                    w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_tx = r_parity;
                if (w_bit_done) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Last stop cycle doubles as the IDLE decision point so that
                // back-to-back frames skip an extra idle cycle.
                if (w_bit_done) begin
                    w_state_next = w_pop_ok ? S_POP : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Baud counter, bit index, shift register and parity
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
        end else begin
            // State changes out of serial states only happen on a bit
            // boundary, so clearing on w_bit_done also clears on entry.
            if (w_counting && !w_bit_done) begin
                r_baud_cnt <= r_baud_cnt + c_baud_one;
            end else begin
                r_baud_cnt <= '0;
            end

            if (r_state == S_LOAD) begin
                r_shift   <= fifo_rdata;
                r_parity  <= ^fifo_rdata;
                r_bit_idx <= '0;
            end else if ((r_state == S_DATA) && w_bit_done) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + c_idx_one;
            end
        end
    end

    assign tx           = w_tx;
    assign fifo_renable = w_renable;
    assign busy         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Directed self-checking bench for fifo_uart_tx. Two instances at
//            CLKS_PER_BIT=4, one without and one with parity, each fed by a
//            behavioural registered-read FIFO. Expected words go into a
//            scoreboard when pushed and are compared as frames are decoded.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_cpb = 4;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic enable   = 1'b1;
    logic enable_p = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUT without parity and its FIFO ----------------
    logic       fifo_renable, tx, busy;
    logic       fifo_empty   = 1'b1;
    logic [7:0] fifo_rdata   = 8'h00;
    logic [7:0] q0[$];
    logic       push0        = 1'b0;
    logic [7:0] push0_data   = 8'h00;
    int         pops0        = 0;
    int         uflow0       = 0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(c_cpb), .PARITY_EN(0)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_renable (fifo_renable),
        .tx           (tx),
        .busy         (busy)
    );

    always @(posedge clk) begin
        if (fifo_renable) begin
            pops0 <= pops0 + 1;
            if (q0.size() != 0) fifo_rdata <= q0.pop_front();
            else                uflow0 <= uflow0 + 1;
        end
        if (push0) q0.push_back(push0_data);
        fifo_empty <= (q0.size() == 0);
    end

    // ---------------- DUT with parity and its FIFO ----------------
    logic       fifo_renable_p, tx_p, busy_p;
    logic       fifo_empty_p = 1'b1;
    logic [7:0] fifo_rdata_p = 8'h00;
    logic [7:0] q1[$];
    logic       push1        = 1'b0;
    logic [7:0] push1_data   = 8'h00;
    int         pops1        = 0;
    int         uflow1       = 0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(c_cpb), .PARITY_EN(1)) u_dut_p (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable_p),
        .fifo_empty   (fifo_empty_p),
        .fifo_rdata   (fifo_rdata_p),
        .fifo_renable (fifo_renable_p),
        .tx           (tx_p),
        .busy         (busy_p)
    );

    always @(posedge clk) begin
        if (fifo_renable_p) begin
            pops1 <= pops1 + 1;
            if (q1.size() != 0) fifo_rdata_p <= q1.pop_front();
            else                uflow1 <= uflow1 + 1;
        end
        if (push1) q1.push_back(push1_data);
        fifo_empty_p <= (q1.size() == 0);
    end

    // ---------------- checking helpers ----------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    logic       last_par_bit = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 1) ? tx_p : tx;
    endfunction

    // Call on a negedge; the word lands in the FIFO on the next posedge.
    task automatic push(input int sel, input logic [7:0] d);
        if (sel == 1) begin push1 = 1'b1; push1_data = d; end
        else          begin push0 = 1'b1; push0_data = d; end
        @(negedge clk);
        push0 = 1'b0;
        push1 = 1'b0;
    endtask

    // Waits for a start bit, samples every cycle of the frame and checks it
    // against the scoreboard. Returns on the negedge of the last stop cycle.
    // waited = tx-high cycles seen before the start bit. drop_bit >= 0 drops
    // enable at the first cycle of that frame bit (frame bit 0 = start).
    task automatic recv(input int sel, input int drop_bit, output int waited);
        int         nb;
        int         unstable;
        int         n;
        logic [10:0] bits;
        logic [7:0]  got;
        logic [7:0]  exp;
        nb       = (sel == 1) ? 11 : 10;
        bits     = '0;
        unstable = 0;
        waited   = 0;
        @(negedge clk);
        while (tx_of(sel) !== 1'b0 && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        chk("frame_start", tx_of(sel), 0);
        if (tx_of(sel) !== 1'b0) return;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < c_cpb; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (b == drop_bit && c == 0) enable = 1'b0;
                if (c == 0) bits[b] = tx_of(sel);
                else if (tx_of(sel) !== bits[b]) unstable++;
            end
        end
        chk("bit_stable", unstable, 0);
        chk("start_bit", bits[0], 0);
        got = bits[8:1];
        n   = (sel == 1) ? sb1.size() : sb0.size();
        chk("sb_nonempty", (n > 0), 1);
        if (n > 0) begin
            exp = (sel == 1) ? sb1.pop_front() : sb0.pop_front();
            chk("data", got, exp);
            if (sel == 1) begin
                last_par_bit = bits[9];
                chk("parity", bits[9], ^exp);
            end
        end
        chk("stop_bit", bits[nb-1], 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         w;
        int         base;
        int         errs;
        int         errs2;
        logic [7:0] d;

        @(negedge clk);

        // Reset with a pop condition present: nothing may start.
        push(0, 8'hCA);
        sb0.push_back(8'hCA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_renable", fifo_renable, 0);
        end
        rst    = 1'b0;
        enable = 1'b0;

        // enable low with a non-empty FIFO: line stays idle.
        errs  = 0;
        errs2 = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) errs++;
            if (fifo_renable !== 1'b0) errs2++;
        end
        chk("en0_tx_high", errs, 0);
        chk("en0_no_pop", errs2, 0);

        // Single frame 0xCA, including start latency.
        base   = pops0;
        enable = 1'b1;
        @(negedge clk);
        chk("lat_renable_e1", fifo_renable, 1);
        chk("lat_busy_e1", busy, 1);
        @(negedge clk);
        chk("lat_renable_e2", fifo_renable, 0);
        chk("lat_tx_e2", tx, 1);
        recv(0, -1, w);
        chk("lat_tx_fall_e3", w, 0);
        chk("single_busy_stop", busy, 1);
        @(negedge clk);
        chk("single_busy_fall", busy, 0);
        repeat (20) @(negedge clk);
        chk("single_one_pop", pops0 - base, 1);

        // Parity instance: 0xCA -> parity 0, 0x07 -> parity 1.
        push(1, 8'hCA);
        sb1.push_back(8'hCA);
        push(1, 8'h07);
        sb1.push_back(8'h07);
        enable_p = 1'b1;
        recv(1, -1, w);
        chk("par_bit_ca", last_par_bit, 0);
        recv(1, -1, w);
        chk("par_bit_07", last_par_bit, 1);
        chk("par_gap", w + c_cpb, 6);
        @(negedge clk);
        chk("par_busy_fall", busy_p, 0);
        chk("par_pops", pops1, 2);

        // Back-to-back frames 0xF0..0xF3.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'hF0 + i);
            push(0, d);
            sb0.push_back(d);
        end
        base   = pops0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            recv(0, -1, w);
            if (i > 0) chk("b2b_gap", w + c_cpb, 6);
            chk("b2b_pops", pops0 - base, i + 1);
        end
        @(negedge clk);
        chk("b2b_busy_fall", busy, 0);

        // Drop enable during data bit 3 of 0x3C: frame completes, 0xA5 stays.
        enable = 1'b0;
        push(0, 8'h3C);
        sb0.push_back(8'h3C);
        push(0, 8'hA5);
        base   = pops0;
        enable = 1'b1;
        recv(0, 4, w);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) errs++;
        end
        chk("drop_idle", errs, 0);
        chk("drop_pops", pops0 - base, 1);
        chk("drop_fifo_kept", fifo_empty, 0);

        // Reset during data bit 3 of 0xA5; next frame must carry 0x69.
        push(0, 8'h69);
        sb0.push_back(8'h69);
        base   = pops0;
        enable = 1'b1;
        w      = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk("rstmid_start", tx, 0);
        repeat (4 * c_cpb + 1) @(negedge clk);
        chk("rstmid_bit3", tx, 0);
        chk("rstmid_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tx", tx, 1);
        chk("rstmid_busy", busy, 0);
        rst = 1'b0;
        recv(0, -1, w);
        chk("rstmid_pops", pops0 - base, 2);
        @(negedge clk);
        chk("rstmid_busy_fall", busy, 0);

        chk("uflow0", uflow0, 0);
        chk("uflow1", uflow1, 0);
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that sits directly downstream of the `fifo` block. It drains the FIFO one word at a time through the FIFO's read port (`renable`/`rdata`/`empty`) and serialises each word as an asynchronous UART frame: start bit, data LSB first, optional even parity, then stop bit. A programmable clocks-per-bit divider sets the bit period. The block pops only when the FIFO reports non-empty, so a FIFO underflow cannot occur.

## Interface
- `DATA_WIDTH`, default 8: word width; must equal the FIFO's `FIFO_WIDTH`.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit after the data bits; 0 omits it.
- `clk` input, 1 bit: the single clock. All logic is rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: permits new pops. Sampled only in `IDLE` and on the last `STOP` cycle.
- `fifo_empty` input, 1 bit: the FIFO's `empty` output.
- `fifo_rdata` input, `DATA_WIDTH` bits: the FIFO's `rdata` output.
- `fifo_renable` output, 1 bit: drives the FIFO's `renable` input.
- `tx` output, 1 bit: serial line, idles high.
- `busy` output, 1 bit: high in every state except `IDLE`.

## Operation
- The FSM has states `IDLE`, `POP`, `LOAD`, `START`, `DATA`, `PARITY`, `STOP`.
- **IDLE**
  - `tx`=1.
  - If `enable`=1 and `fifo_empty`=0, go to `POP`. Otherwise stay in `IDLE`.
- **POP**
  - Lasts exactly 1 cycle.
  - `fifo_renable`=1 in this cycle only.
  - Always goes to `LOAD`.
- **LOAD**
  - Lasts exactly 1 cycle.
  - `fifo_rdata` is valid in this cycle (the FIFO read is registered). It is captured into the shift register at the end of the cycle.
  - The parity bit is computed from the captured word as the XOR of all its bits.
  - Goes to `START`.
- **START**
  - `tx`=0 for `CLKS_PER_BIT` cycles, then go to `DATA`.
- **DATA**
  - `tx` = shift register bit 0 for each bit period.
  - The register shifts right at the end of each bit period.
  - A bit index counts 0..`DATA_WIDTH`-1.
  - After the last bit, go to `PARITY` if `PARITY_EN`=1, else to `STOP`.
- **PARITY**
  - `tx` = parity bit (XOR of all data bits) for `CLKS_PER_BIT` cycles, then go to `STOP`.
- **STOP**
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - On the last cycle: if `enable`=1 and `fifo_empty`=0, go to `POP` (back-to-back frames). Otherwise go to `IDLE`.
- **Bit counters**
  - The baud counter runs 0..`CLKS_PER_BIT`-1 and resets to 0 at every bit boundary and on every state entry.
  - The counter width is $clog2(`CLKS_PER_BIT`). The bit-index width is $clog2(`DATA_WIDTH`)+1.
- `fifo_renable` is asserted for exactly one cycle per frame. It is never asserted unless `fifo_empty`=0 was sampled on the preceding edge.

## Timing
- **Reset values** (in the cycle after a `rst`=1 edge): state `IDLE`, `tx`=1, `fifo_renable`=0, `busy`=0, counters and shift register 0.
- **Start latency:** with `enable`=1 and `fifo_empty`=0 sampled in `IDLE` at edge E:
  - `fifo_renable`=1 in cycle E+1.
  - Data captured at the end of cycle E+2.
  - `tx` falls in cycle E+3.
- **Frame length:** (2 + `DATA_WIDTH` + `PARITY_EN`) × `CLKS_PER_BIT` cycles, measured from `tx` falling to the end of `STOP`.
- **Inter-frame gap:** `tx` stays high for exactly `CLKS_PER_BIT` + 2 cycles (stop bit + `POP` + `LOAD`) between frames, when the FIFO is non-empty at the end of `STOP`.
- **`enable` deasserted mid-frame:** the current frame completes unchanged, then the FSM returns to `IDLE` with no further pop.
- **`fifo_empty` changes** while the FSM is outside `IDLE` or the last `STOP` cycle: ignored.
- **`rst` mid-frame:**
  - `tx`=1 and state `IDLE` on the next cycle.
  - The popped word is discarded, not retransmitted.
  - `rst` during `POP` still completes the FIFO read already in flight (the FIFO consumes one word), but that word is discarded.
- **`rst` and a pop condition on the same edge:** reset wins; `fifo_renable` stays 0.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `fifo_empty`=0 and `enable`=1 → `tx`=1, `busy`=0, `fifo_renable`=0 throughout.
- **Single frame:** `CLKS_PER_BIT`=4, `PARITY_EN`=0, FIFO holds 0xCA.
  - `fifo_renable` pulses for 1 cycle.
  - `tx`, per 4-cycle bit: 0, then 0,1,0,1,0,0,1,1, then 1.
  - `busy` falls after 40 cycles of frame.
  - `fifo_renable` does not assert again while `fifo_empty`=1.
- **Parity:** `PARITY_EN`=1, words 0xCA and 0x07 → parity bit 0 for 0xCA and 1 for 0x07; frame length 44 cycles at `CLKS_PER_BIT`=4.
- **Back-to-back:** FIFO holds 0xF0..0xF3 → 4 frames in order, each with exactly one `fifo_renable` pulse, and a `tx`-high gap of 6 cycles between frames (`CLKS_PER_BIT`=4).
- **Enable control:**
  - `enable`=0 with a non-empty FIFO for 50 cycles → no `fifo_renable` and `tx`=1.
  - Drop `enable` mid-frame → that frame completes, then the FSM returns to `IDLE`.
- **Reset mid-frame:** assert `rst` during bit 3 of 0xA5 → `tx`=1 and `busy`=0 on the next cycle. After release, the next frame carries the following FIFO word, not 0xA5.
